mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single data-memory port between the instruction-fetch stage and the load/store path of the RISC-V core. It arbitrates the two requesters, registers the winning request, and drives the memory-side request/accept handshake. It then routes the read response back to the owner. The block sits between the fetch/execute stages and the memory wrapper. It carries the decoder's `memCtrl` (funct3 width/sign code) through unchanged.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 4: number of consecutive load/store grants with fetch waiting before fetch is forced to win (used only with the macro).

Ports:
- `clk`  in  1: the single clock. All state is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `if_req`  in  1: fetch request. Held until `if_gnt`.
- `if_addr`  in  ADDR_W: fetch address.
- `if_gnt`  out  1: fetch request accepted (one cycle).
- `if_rvalid`  out  1: fetch data valid (one cycle).
- `if_rdata`  out  DATA_W: fetch data.
- `ls_req`  in  1: load/store request. Held until `ls_gnt`.
- `ls_we`  in  1: 1 = store, 0 = load.
- `ls_addr`  in  ADDR_W: load/store address.
- `ls_wdata`  in  DATA_W: store data.
- `ls_ctrl`  in  3: funct3 width/sign code.
- `ls_gnt`  out  1: load/store request accepted (one cycle).
- `ls_done`  out  1: load data valid or store accepted by memory (one cycle).
- `ls_rdata`  out  DATA_W: load data.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_ctrl`  out  3: funct3 code passed to memory.
- `mem_ready`  in  1: memory accepts the request this cycle.
- `mem_rvalid`  in  1: read data valid.
- `mem_rdata`  in  DATA_W: read data.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when any request is present.
  - ISSUE → IDLE when `mem_ready` and it is a store.
  - ISSUE → WAIT when `mem_ready` and it is a read.
  - WAIT → IDLE on `mem_rvalid`.
- Arbitration happens only in IDLE.
  - Load/store beats fetch.
  - Exception (macro only): the starvation counter equals STARVE_LIMIT. Then fetch wins.
- Grant:
  - The `*_gnt` output is combinational in IDLE for the winner only.
  - In the same cycle, the request fields are latched into the issue registers and the owner is recorded.
  - A fetch grant latches `mem_we=0` and `mem_ctrl=3'b010`.
- `mem_*` outputs come from the issue registers. They are stable while `mem_req=1` and `mem_ready=0`.
- `mem_req` is 1 only in ISSUE.
- Response routing:
  - `if_rvalid` = `mem_rvalid` AND WAIT AND owner=IF.
  - `ls_done` = the same condition with owner=LS, OR (ISSUE AND `mem_ready` AND `mem_we`).
  - Rdata outputs pass `mem_rdata` through combinationally.
- `mem_rvalid` outside WAIT is ignored. This covers a late response after reset and a response in the accept cycle.
- Reset values: state IDLE, owner IF, issue registers 0, starvation counter 0. All outputs are 0.
- Reset mid-transaction abandons it. No `*_rvalid` or `ls_done` is produced for it.

## Timing
- Grant latency: 0 cycles from a request in IDLE.
- Read, minimum: request/grant at cycle 0, `mem_req` at cycle 1, `mem_rvalid` earliest at cycle 2, owner's valid at cycle 2, next grant at cycle 3.
- Store, minimum: grant at cycle 0, `mem_req`+`mem_ready` and `ls_done` at cycle 1, next grant at cycle 2.
- Throughput: one transaction in flight. No pipelining.
- Simultaneous `if_req` and `ls_req` in IDLE: exactly one `*_gnt`. The loser keeps its request asserted and is re-arbitrated at the next IDLE.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - The counter increments on each LS grant made while `if_req=1`, saturating at STARVE_LIMIT.
  - It clears on an IF grant, and on any IDLE arbitration cycle with `if_req=0`.
  - At STARVE_LIMIT, fetch wins a tie.
- Not defined: strict load/store priority. The counter is not instantiated.

## Structure
- `mem_arb_pkg`: the `arb_state_t` enum (IDLE, ISSUE, WAIT) and the `arb_owner_t` enum (IF, LS). The 3'b010 fetch-width constant also lives here.
- Sub-module `mem_arb_starve_ctr`: the saturating counter with clear. It is instantiated only under `MEM_ARB_STARVE_EN`.

## Test plan
- Fetch read, `if_addr=0x100`, memory returns `0xDEADBEEF` one cycle after ready → `if_gnt` at c0, `mem_req` at c1, `if_rvalid`/`if_rdata=0xDEADBEEF` at c2.
- Store `ls_addr=0x200`, `ls_wdata=0x12345678`, `ls_ctrl=3'b000`, `mem_ready` low for 3 cycles → `mem_*` stable throughout, single `ls_done` on the ready cycle.
- `if_req` and `ls_req` both asserted at c0 → only `ls_gnt`. `if_gnt` follows at the next IDLE.
- With the macro and STARVE_LIMIT=4, `ls_req` and `if_req` held continuously → 4 LS grants, then 1 IF grant, then the counter restarts. Without the macro → fetch is never granted.
- `rst_n` pulsed low during WAIT, then `mem_rvalid` arrives → no `if_rvalid`/`ls_done`, state IDLE, all outputs 0.
- `mem_rvalid` asserted during IDLE and ISSUE → ignored, no valid outputs.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the data-memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, ISSUE, WAIT)
//   arb_owner_t : owner of the transaction in flight (IF = fetch, LS = load/store)
//   FETCH_CTRL  : funct3 code issued for every instruction fetch (word access)
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        IF = 1'b0,
        LS = 1'b1
    } arb_owner_t;

    localparam logic [2:0] FETCH_CTRL = 3'b010;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
//   Saturating up-counter with synchronous clear; tracks consecutive
//   load/store grants made while fetch was waiting.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : count one more starved grant (saturates at LIMIT)
//     clr        : clear the count (has priority over inc)
//     sat        : count has reached LIMIT
module mem_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign sat = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single data-memory port between instruction fetch (IF) and
//   the load/store path (LS). Arbitrates in IDLE, registers the winning
//   request, runs the mem_req/mem_ready handshake and routes the read
//   response back to the recorded owner. One transaction in flight.
//   Build option: define MEM_ARB_STARVE_EN to let fetch win a tie after
//   STARVE_LIMIT consecutive load/store grants made while fetch waited;
//   otherwise load/store has strict priority.
//   Ports:
//     clk, rst_n                      : clock, asynchronous active-low reset
//     if_req/if_addr                  : fetch request (held until if_gnt)
//     if_gnt/if_rvalid/if_rdata       : fetch grant and read response
//     ls_req/ls_we/ls_addr/ls_wdata/ls_ctrl : load/store request
//     ls_gnt/ls_done/ls_rdata         : load/store grant and completion
//     mem_req/mem_we/mem_addr/mem_wdata/mem_ctrl : memory request fields
//     mem_ready/mem_rvalid/mem_rdata  : memory accept and read response
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [2:0]        ls_ctrl,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_ctrl,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_nxt;
    arb_owner_t        owner;
    logic              iss_we;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;
    logic [2:0]        iss_ctrl;

    logic starve_hit;
    logic fetch_wins;
    logic rd_resp;

`ifdef MEM_ARB_STARVE_EN
    mem_arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (ls_gnt & if_req),
        .clr  (if_gnt | ((state == IDLE) & ~if_req)),
        .sat  (starve_hit)
    );
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = ^STARVE_LIMIT;
    assign starve_hit        = 1'b0;
`endif

    assign fetch_wins = if_req & (~ls_req | starve_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if_gnt = fetch_wins;
                ls_gnt = ls_req & ~fetch_wins;
                if (if_req || ls_req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready) begin
                    state_nxt = iss_we ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue registers load only on a grant, so mem_* hold steady through
    // any number of mem_ready=0 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= IF;
            iss_we    <= 1'b0;
            iss_addr  <= '0;
            iss_wdata <= '0;
            iss_ctrl  <= '0;
        end else if (if_gnt) begin
            owner     <= IF;
            iss_we    <= 1'b0;
            iss_addr  <= if_addr;
            iss_wdata <= '0;
            iss_ctrl  <= FETCH_CTRL;
        end else if (ls_gnt) begin
            owner     <= LS;
            iss_we    <= ls_we;
            iss_addr  <= ls_addr;
            iss_wdata <= ls_wdata;
            iss_ctrl  <= ls_ctrl;
        end
    end

    assign mem_req   = (state == ISSUE);
    assign mem_we    = iss_we;
    assign mem_addr  = iss_addr;
    assign mem_wdata = iss_wdata;
    assign mem_ctrl  = iss_ctrl;

    // mem_rvalid only counts while waiting for our own read.
    assign rd_resp   = (state == WAIT) & mem_rvalid;
    assign if_rvalid = rd_resp & (owner == IF);
    assign ls_done   = (rd_resp & (owner == LS)) | (mem_req & mem_ready & iss_we);

    // Read data is passed through but zeroed when not valid for that owner,
    // so an idle or reset arbiter presents all-zero outputs.
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = (rd_resp && (owner == LS)) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A behavioural memory answers
//   mem_req with a programmable accept delay and read latency; requester
//   tasks push the expected transaction into a scoreboard at grant time and
//   a negedge monitor compares mem_* fields and responses against it.
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [AW-1:0] ls_addr = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic [2:0]    ls_ctrl = '0;
    logic          ls_gnt, ls_done;
    logic [DW-1:0] ls_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_ctrl;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ctrl   (ls_ctrl),
        .ls_gnt    (ls_gnt),
        .ls_done   (ls_done),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ctrl  (mem_ctrl),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic          is_if;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    ctrl;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    bit   glog[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_resp = 0;
    int   ready_delay = 0;
    int   rvalid_delay = 1;
    logic inject = 1'b0;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},   {if_gnt, ls_gnt}, 0);
        check({tag, "_vld"},   {if_rvalid, ls_done}, 0);
        check({tag, "_rdata"}, {if_rdata, ls_rdata}, 0);
        check({tag, "_req"},   {mem_req, mem_we, mem_ctrl}, 0);
        check({tag, "_addr"},  mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

    // Memory: accepts after ready_delay ISSUE cycles, returns read data
    // rvalid_delay cycles after the accept. Drives at +2 to avoid racing
    // the stimulus written at +1.
    initial begin : mem_proc
        int            cyc;
        int            rv_cnt;
        logic [AW-1:0] rv_addr;
        cyc = 0;
        rv_cnt = 0;
        rv_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_rvalid = inject;
            mem_rdata  = 32'hBAD0_BAD0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_model(rv_addr);
                end
            end
            if (mem_req) begin
                mem_ready = (cyc >= ready_delay);
                cyc++;
                if (mem_ready && !mem_we) begin
                    rv_cnt  = rvalid_delay;
                    rv_addr = mem_addr;
                end
            end else begin
                mem_ready = 1'b0;
                cyc = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (if_gnt || ls_gnt) begin
                check("one_gnt", if_gnt & ls_gnt, 0);
                check("gnt_wo_req", {if_gnt & ~if_req, ls_gnt & ~ls_req}, 0);
            end
            if (mem_req) begin
                if (sb.size() == 0) begin
                    check("req_no_txn", mem_req, 0);
                end else begin
                    check("mem_addr", mem_addr, sb[0].addr);
                    check("mem_we",   mem_we,   sb[0].we);
                    check("mem_ctrl", mem_ctrl, sb[0].ctrl);
                    if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
                end
            end
            if (sb.size() == 0) begin
                check("no_resp", {if_rvalid, ls_done}, 0);
            end else if (if_rvalid || ls_done) begin
                e = sb.pop_front();
                n_resp++;
                check("resp_owner", {if_rvalid, ls_done}, {e.is_if, ~e.is_if});
                if (e.is_if) check("if_rdata", if_rdata, e.rdata);
                else if (!e.we) check("ls_rdata", ls_rdata, e.rdata);
            end
        end
    end

    task automatic req_if(input logic [AW-1:0] a, output int waited);
        bit got;
        got = 0;
        waited = 0;
        if_req = 1'b1;
        if_addr = a;
        while (!got && waited < 200) begin
            @(negedge clk);
            if (if_gnt) got = 1;
            else waited++;
        end
        if (got) begin
            sb.push_back('{1'b1, 1'b0, a, 32'h0, 3'b010, mem_model(a)});
            glog.push_back(1'b1);
        end else begin
            check("if_gnt_timeout", if_gnt, 1);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic req_ls(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [2:0] c, output int waited);
        bit got;
        got = 0;
        waited = 0;
        ls_req = 1'b1;
        ls_we = we;
        ls_addr = a;
        ls_wdata = d;
        ls_ctrl = c;
        while (!got && waited < 200) begin
            @(negedge clk);
            if (ls_gnt) got = 1;
            else waited++;
        end
        if (got) begin
            sb.push_back('{1'b0, we, a, d, c, we ? 32'h0 : mem_model(a)});
            glog.push_back(1'b0);
        end else begin
            check("ls_gnt_timeout", ls_gnt, 1);
        end
        @(posedge clk);
        #1;
        ls_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int w, w1, w2, r0;
        bit exp_seq [12];

        // Reset state
        #3;
        check_zero("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fetch read: gnt c0, mem_req c1, if_rvalid c2
        @(posedge clk);
        #1;
        req_if(32'h100, w);
        check("t1_gnt_latency", w, 0);
        @(negedge clk);
        check("t1_c1_req", mem_req, 1);
        check("t1_c1_addr", mem_addr, 32'h100);
        check("t1_c1_vld", if_rvalid, 0);
        @(negedge clk);
        check("t1_c2_vld", if_rvalid, 1);
        check("t1_c2_rdata", if_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t1_c3_idle", {mem_req, if_rvalid}, 0);

        // Store held off by mem_ready for 3 cycles
        ready_delay = 3;
        r0 = n_resp;
        @(posedge clk);
        #1;
        req_ls(1'b1, 32'h200, 32'h1234_5678, 3'b000, w);
        repeat (3) begin
            @(negedge clk);
            check("t2_wait", {mem_req, mem_ready, ls_done}, 3'b100);
        end
        @(negedge clk);
        check("t2_accept", {mem_req, mem_ready, ls_done}, 3'b111);
        @(negedge clk);
        check("t2_idle", {mem_req, ls_done}, 0);
        check("t2_done_cnt", n_resp - r0, 1);

        // Simultaneous requests: load/store first, fetch at next IDLE
        ready_delay = 0;
        glog.delete();
        @(posedge clk);
        #1;
        fork
            req_if(32'h300, w1);
            req_ls(1'b0, 32'h400, 32'h0, 3'b100, w2);
        join
        drain();
        check("t3_gnt_cnt", glog.size(), 2);
        if (glog.size() == 2) begin
            check("t3_first_ls", glog[0], 0);
            check("t3_then_if", glog[1], 1);
        end
        check("t3_ls_wait", w2, 0);

        // Fetch held against a stream of stores
`ifdef MEM_ARB_STARVE_EN
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
`endif
        glog.delete();
        @(posedge clk);
        #1;
        fork
            for (int i = 0; i < 2; i++) req_if(32'h500 + 32'(i * 4), w1);
            for (int j = 0; j < 10; j++) req_ls(1'b1, 32'h600 + 32'(j * 4), 32'(j), 3'b010, w2);
        join
        drain();
        check("t4_gnt_cnt", glog.size(), 12);
        if (glog.size() == 12) begin
            for (int k = 0; k < 12; k++) check($sformatf("t4_gnt%0d", k), glog[k], exp_seq[k]);
        end

        // Reset during WAIT; the late response must be ignored
        rvalid_delay = 3;
        @(posedge clk);
        #1;
        req_if(32'h700, w);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #2;
        check_zero("t5_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rvalid) break;
        end
        check("t5_late_rvalid", mem_rvalid, 1);
        check_zero("t5_after");
        rvalid_delay = 1;

        // Stray mem_rvalid in IDLE and in ISSUE
        @(posedge clk);
        #1;
        inject = 1'b1;
        @(negedge clk);
        check_zero("t6_idle");
        @(posedge clk);
        #1;
        inject = 1'b0;
        ready_delay = 2;
        r0 = n_resp;
        req_ls(1'b0, 32'h800, 32'h0, 3'b100, w);
        inject = 1'b1;
        @(negedge clk);
        check("t6_issue_vld", {mem_req, if_rvalid, ls_done}, 3'b100);
        @(posedge clk);
        #1;
        inject = 1'b0;
        drain();
        check("t6_resp_cnt", n_resp - r0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
